// File: rtl/ddram_upload_reader.sv
// ddram_upload_reader
//   Serves HPS ioctl upload reads from DDRAM. Each ioctl_rd strobe is answered
//   with a byte-swapped 16-bit word on ioctl_din, fetched over a toggle
//   req/ack read port. ioctl_wait is held while a fetch is outstanding. A
//   one-word prefetch buffer keeps sequential uploads free of stalls.
// Ports
//   clk_sys, reset          : clock, synchronous active-high reset
//   ioctl_upload            : upload session active
//   ioctl_rd, ioctl_addr    : one-cycle read strobe and even byte address
//   ioctl_din, ioctl_wait   : returned word, stall request to HPS
//   mem_addr, mem_req       : DDRAM word address and toggle request
//   mem_ack, mem_data       : toggle acknowledge and read data
module ddram_upload_reader #(
    parameter logic [21:0] BASE       = 22'h200000,
    parameter int unsigned SIZE_BYTES = 65536,
    parameter bit          PREFETCH   = 1'b1
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_upload,
    input  logic        ioctl_rd,
    input  logic [24:0] ioctl_addr,
    output logic [15:0] ioctl_din,
    output logic        ioctl_wait,
    output logic [21:0] mem_addr,
    output logic        mem_req,
    input  logic        mem_ack,
    input  logic [15:0] mem_data
);

    localparam logic [25:0] SIZE_L = 26'(SIZE_BYTES);

    typedef enum logic [2:0] {
        ST_IDLE, ST_FETCH, ST_WAIT_ACK, ST_PF_ISSUE, ST_PF_WAIT, ST_DRAIN
    } state_t;

    state_t      state_r;
    logic [15:0] din_r;
    logic        wait_r;
    logic [21:0] mem_addr_r;
    logic        mem_req_r;
    logic [24:0] cur_addr_r;    // byte address of the word being served
    logic [15:0] buf_r;         // prefetched word, already byte-swapped
    logic [24:0] buf_addr_r;    // byte address of the prefetch target
    logic        buf_valid_r;
    logic        pf_hit_r;      // HPS is waiting for the in-flight prefetch word
    logic        pf_redir_r;    // HPS is waiting for a different word after the in-flight access
    logic        upload_d_r;

    logic [24:0] rd_addr_s;
    logic        rd_oor_s;
    logic        rd_s;
    logic        ack_s;
    logic [25:0] pf_addr_s;
    logic        pf_oor_s;
    logic        upload_rise_s;
    logic        buf_hit_s;
    logic        unused_addr_lsb_s;

    function automatic logic [21:0] map_addr(input logic [24:0] byte_addr);
        return BASE + byte_addr[22:1];
    endfunction

    function automatic logic [15:0] swap_bytes(input logic [15:0] w);
        return {w[7:0], w[15:8]};
    endfunction

    assign unused_addr_lsb_s = ioctl_addr[0];

    // Request decode, handshake status and prefetch address
    always_comb begin
        rd_addr_s     = {ioctl_addr[24:1], 1'b0};
        rd_oor_s      = ({1'b0, rd_addr_s} >= SIZE_L);
        rd_s          = ioctl_rd & ioctl_upload & ~wait_r;
        ack_s         = (mem_ack == mem_req_r);
        pf_addr_s     = {1'b0, cur_addr_r} + 26'd2;
        pf_oor_s      = (pf_addr_s >= SIZE_L);
        upload_rise_s = ioctl_upload & ~upload_d_r;
        buf_hit_s     = buf_valid_r & (buf_addr_r == rd_addr_s);
    end

    // Main state machine; mem_req and mem_addr are kept across reset so an
    // in-flight toggle is never disturbed and is drained instead
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_r     <= ack_s ? ST_IDLE : ST_DRAIN;
            din_r       <= 16'h0000;
            wait_r      <= 1'b0;
            cur_addr_r  <= 25'd0;
            buf_r       <= 16'h0000;
            buf_addr_r  <= 25'd0;
            buf_valid_r <= 1'b0;
            pf_hit_r    <= 1'b0;
            pf_redir_r  <= 1'b0;
            upload_d_r  <= ioctl_upload;
        end else begin
            upload_d_r <= ioctl_upload;
            if (!ioctl_upload || upload_rise_s) begin
                // outside a session, or at its start: abandon any pending read
                wait_r     <= 1'b0;
                pf_hit_r   <= 1'b0;
                pf_redir_r <= 1'b0;
                if (upload_rise_s) begin
                    buf_valid_r <= 1'b0;
                end
                if (state_r != ST_IDLE) begin
                    state_r <= ack_s ? ST_IDLE : ST_DRAIN;
                end
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (rd_s) begin
                            if (rd_oor_s) begin
                                din_r <= 16'hFFFF;
                            end else if (buf_hit_s) begin
                                din_r <= buf_r;
                                if (PREFETCH) begin
                                    cur_addr_r <= rd_addr_s;
                                    state_r    <= ST_PF_ISSUE;
                                end
                            end else begin
                                wait_r     <= 1'b1;
                                cur_addr_r <= rd_addr_s;
                                state_r    <= ST_FETCH;
                            end
                        end
                    end
                    ST_FETCH: begin
                        if (ack_s) begin
                            mem_addr_r <= map_addr(cur_addr_r);
                            mem_req_r  <= ~mem_req_r;
                            state_r    <= ST_WAIT_ACK;
                        end
                    end
                    ST_WAIT_ACK: begin
                        if (ack_s) begin
                            din_r   <= swap_bytes(mem_data);
                            wait_r  <= 1'b0;
                            state_r <= PREFETCH ? ST_PF_ISSUE : ST_IDLE;
                        end
                    end
                    ST_PF_ISSUE: begin
                        buf_valid_r <= 1'b0;
                        if (rd_s && (pf_oor_s || rd_addr_s != pf_addr_s[24:0])) begin
                            // HPS jumped elsewhere before the prefetch went out
                            if (rd_oor_s) begin
                                din_r   <= 16'hFFFF;
                                state_r <= ST_IDLE;
                            end else begin
                                wait_r     <= 1'b1;
                                cur_addr_r <= rd_addr_s;
                                state_r    <= ST_FETCH;
                            end
                        end else if (pf_oor_s) begin
                            state_r <= ST_IDLE;
                        end else if (ack_s) begin
                            mem_addr_r <= map_addr(pf_addr_s[24:0]);
                            mem_req_r  <= ~mem_req_r;
                            buf_addr_r <= pf_addr_s[24:0];
                            if (rd_s) begin
                                // strobe for exactly the prefetch word
                                pf_hit_r <= 1'b1;
                                wait_r   <= 1'b1;
                            end
                            state_r <= ST_PF_WAIT;
                        end
                    end
                    ST_PF_WAIT: begin
                        if (ack_s) begin
                            if (pf_hit_r) begin
                                din_r      <= swap_bytes(mem_data);
                                wait_r     <= 1'b0;
                                pf_hit_r   <= 1'b0;
                                cur_addr_r <= buf_addr_r;
                                state_r    <= ST_PF_ISSUE;
                            end else if (pf_redir_r) begin
                                pf_redir_r <= 1'b0;
                                state_r    <= ST_FETCH;
                            end else if (rd_s && !rd_oor_s && rd_addr_s == buf_addr_r) begin
                                din_r      <= swap_bytes(mem_data);
                                cur_addr_r <= buf_addr_r;
                                state_r    <= ST_PF_ISSUE;
                            end else begin
                                buf_r       <= swap_bytes(mem_data);
                                buf_valid_r <= 1'b1;
                                if (rd_s && rd_oor_s) begin
                                    din_r   <= 16'hFFFF;
                                    state_r <= ST_IDLE;
                                end else if (rd_s) begin
                                    wait_r     <= 1'b1;
                                    cur_addr_r <= rd_addr_s;
                                    state_r    <= ST_FETCH;
                                end else begin
                                    state_r <= ST_IDLE;
                                end
                            end
                        end else if (rd_s) begin
                            if (rd_oor_s) begin
                                din_r <= 16'hFFFF;
                            end else if (rd_addr_s == buf_addr_r) begin
                                pf_hit_r <= 1'b1;
                                wait_r   <= 1'b1;
                            end else begin
                                // the toggle in flight cannot be cancelled
                                pf_redir_r <= 1'b1;
                                wait_r     <= 1'b1;
                                cur_addr_r <= rd_addr_s;
                            end
                        end
                    end
                    ST_DRAIN: begin
                        if (ack_s) begin
                            pf_redir_r <= 1'b0;
                            state_r    <= pf_redir_r ? ST_FETCH : ST_IDLE;
                        end else if (rd_s) begin
                            // queue the read behind the stale access
                            if (rd_oor_s) begin
                                din_r <= 16'hFFFF;
                            end else begin
                                pf_redir_r <= 1'b1;
                                wait_r     <= 1'b1;
                                cur_addr_r <= rd_addr_s;
                            end
                        end
                    end
                    default: begin
                        wait_r  <= 1'b0;
                        state_r <= ack_s ? ST_IDLE : ST_DRAIN;
                    end
                endcase
            end
        end
    end

    assign ioctl_din  = din_r;
    assign ioctl_wait = wait_r;
    assign mem_addr   = mem_addr_r;
    assign mem_req    = mem_req_r;

endmodule

// File: tb/tb_ddram_upload_reader.sv
// Two instances share clock, reset, upload and address: u0 uses default
// parameters, u1 uses BASE=22'h3FFFFF and PREFETCH=0. Each has its own read
// strobe and its own toggle-handshake memory responder.
module tb_ddram_upload_reader;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        ioctl_upload;
    logic [1:0]  rd;
    logic [24:0] ioctl_addr;
    logic [15:0] din [2];
    logic [1:0]  wt;
    logic [21:0] maddr [2];
    logic [1:0]  mreq;
    logic [1:0]  mack = 2'b00;
    logic [15:0] mdata [2];

    int          tests = 0;
    int          fails = 0;
    int          lat = 8;
    int          cnt [2];
    logic [1:0]  busy = 2'b00;
    logic [1:0]  prev_req;
    bit          log_init = 1'b0;
    int          tog_cnt [2];
    logic [21:0] tog_log0 [0:2047];
    logic [21:0] tog_log1 [0:2047];
    logic [15:0] q0 [$];
    logic [15:0] q1 [$];
    bit          abort_mon = 1'b0;
    logic [1:0]  seen;
    int          wcyc;

    always #5 clk_sys = ~clk_sys;

    ddram_upload_reader u0 (
        .clk_sys(clk_sys), .reset(reset), .ioctl_upload(ioctl_upload),
        .ioctl_rd(rd[0]), .ioctl_addr(ioctl_addr), .ioctl_din(din[0]),
        .ioctl_wait(wt[0]), .mem_addr(maddr[0]), .mem_req(mreq[0]),
        .mem_ack(mack[0]), .mem_data(mdata[0]));

    ddram_upload_reader #(.BASE(22'h3FFFFF), .SIZE_BYTES(65536), .PREFETCH(1'b0)) u1 (
        .clk_sys(clk_sys), .reset(reset), .ioctl_upload(ioctl_upload),
        .ioctl_rd(rd[1]), .ioctl_addr(ioctl_addr), .ioctl_din(din[1]),
        .ioctl_wait(wt[1]), .mem_addr(maddr[1]), .mem_req(mreq[1]),
        .mem_ack(mack[1]), .mem_data(mdata[1]));

    // DDRAM contents: word 16'h1234 at 22'h200000, pseudo-random elsewhere
    function automatic logic [15:0] word_at(input logic [21:0] a);
        logic [21:0] off;
        logic [31:0] t;
        off = a - 22'h200000;
        t = 32'(off) * 32'd40503 + 32'h1234;
        return t[15:0];
    endfunction

    // Reference: what HPS must read at byte address a from instance id
    function automatic logic [15:0] exp_word(input int id, input logic [24:0] a);
        logic [24:0] a2;
        logic [21:0] w;
        logic [15:0] d;
        a2 = a & 25'h1FFFFFE;
        if (a2 >= 25'h10000) return 16'hFFFF;
        w = ((id == 0) ? 22'h200000 : 22'h3FFFFF) + 22'(a2 >> 1);
        d = word_at(w);
        return {d[7:0], d[15:8]};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic tmo(input string name);
        tests++;
        fails++;
        $display("FAIL %s: timeout waiting for DUT", name);
    endtask

    // Memory responder: acknowledges each toggle lat cycles after it is issued
    always @(posedge clk_sys) begin
        for (int i = 0; i < 2; i++) begin
            if (busy[i]) begin
                if (cnt[i] == 0) begin
                    mack[i]  <= mreq[i];
                    mdata[i] <= word_at(maddr[i]);
                    busy[i]  <= 1'b0;
                end else begin
                    cnt[i] <= cnt[i] - 1;
                end
            end else if (mreq[i] != mack[i]) begin
                busy[i] <= 1'b1;
                cnt[i]  <= lat - 2;
            end
        end
    end

    // Toggle logger: counts mem_req toggles and the address of each
    always @(negedge clk_sys) begin
        if (!log_init) begin
            prev_req = mreq;
            log_init = 1'b1;
            tog_cnt[0] = 0;
            tog_cnt[1] = 0;
        end else begin
            if (mreq[0] != prev_req[0] && tog_cnt[0] < 2048) begin
                tog_log0[tog_cnt[0]] = maddr[0];
                tog_cnt[0]++;
            end
            if (mreq[1] != prev_req[1] && tog_cnt[1] < 2048) begin
                tog_log1[tog_cnt[1]] = maddr[1];
                tog_cnt[1]++;
            end
            prev_req = mreq;
        end
    end

    // Scoreboard monitor: on an accepted strobe, pop the expected word and
    // compare once the instance drops ioctl_wait
    task automatic mon(input int id);
        logic [15:0] e;
        int n;
        @(posedge clk_sys);
        if (rd[id] && ioctl_upload && !wt[id] && !reset) begin
            if ((id == 0 ? q0.size() : q1.size()) == 0) begin
                tmo($sformatf("u%0d_queue_empty", id));
            end else begin
                e = (id == 0) ? q0.pop_front() : q1.pop_front();
                n = 0;
                @(negedge clk_sys);
                while (wt[id] && !abort_mon && n < 300) begin
                    @(negedge clk_sys);
                    n++;
                end
                if (abort_mon) begin
                    e = 16'h0000;
                end else if (n >= 300) begin
                    tmo($sformatf("u%0d_din_wait", id));
                end else begin
                    chk($sformatf("u%0d_din", id), {16'h0, din[id]}, {16'h0, e});
                end
            end
        end
    endtask

    always mon(0);
    always mon(1);

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) @(negedge clk_sys);
    endtask

    // Issue one strobe to the instances in mask, then wait for both to be free
    task automatic strobe(input logic [1:0] mask, input logic [24:0] a);
        int n;
        ioctl_addr = a;
        rd = mask;
        if (ioctl_upload) begin
            if (mask[0]) q0.push_back(exp_word(0, a));
            if (mask[1]) q1.push_back(exp_word(1, a));
        end
        seen = 2'b00;
        wcyc = 0;
        @(negedge clk_sys);
        rd = 2'b00;
        n = 0;
        while ((wt[0] || wt[1]) && n < 300) begin
            seen = seen | wt;
            if (wt[0]) wcyc++;
            @(negedge clk_sys);
            n++;
        end
        if (n >= 300) tmo("strobe_wait");
    endtask

    initial begin
        int n0, n1, waits;
        logic req_before;
        logic [24:0] last, a;
        int r;
        reset = 1'b1;
        ioctl_upload = 1'b0;
        rd = 2'b00;
        ioctl_addr = 25'd0;
        idle(3);
        chk("reset_din0", {16'h0, din[0]}, 32'h0);
        chk("reset_wait0", {31'h0, wt[0]}, 32'h0);
        chk("reset_din1", {16'h0, din[1]}, 32'h0);
        chk("reset_wait1", {31'h0, wt[1]}, 32'h0);
        reset = 1'b0;
        ioctl_upload = 1'b1;
        idle(3);

        // sequential read: first word stalls, second comes from the prefetch
        strobe(2'b01, 25'd0);
        chk("t1_wait_cycles_ok", {31'h0, (wcyc >= 8 && wcyc <= 12)}, 32'h1);
        idle(14);
        strobe(2'b01, 25'd2);
        chk("t1_hit_no_wait", {31'h0, seen[0]}, 32'h0);

        // jump while prefetch of 4 is in flight
        idle(2);
        n0 = tog_cnt[0];
        strobe(2'b01, 25'h100);
        chk("t2_wait_high", {31'h0, seen[0]}, 32'h1);
        chk("t2_refetch_addr", {10'h0, tog_log0[n0]}, {10'h0, 22'h200080});

        // out of window
        idle(20);
        n0 = tog_cnt[0];
        strobe(2'b01, 25'h10000);
        chk("t3_no_wait", {31'h0, seen[0]}, 32'h0);
        idle(3);
        chk("t3_no_toggle", tog_cnt[0] - n0, 32'h0);

        // upload low ignores strobes; the new session invalidates the buffer
        idle(20);
        ioctl_upload = 1'b0;
        idle(2);
        n0 = tog_cnt[0];
        strobe(2'b01, 25'h102);
        chk("upl_low_no_wait", {31'h0, seen[0]}, 32'h0);
        chk("upl_low_no_toggle", tog_cnt[0] - n0, 32'h0);
        ioctl_upload = 1'b1;
        idle(2);
        strobe(2'b01, 25'h102);
        chk("upl_rise_miss", {31'h0, seen[0]}, 32'h1);

        // reset while waiting for an ack
        idle(20);
        n0 = tog_cnt[0];
        ioctl_addr = 25'h200;
        rd = 2'b01;
        q0.push_back(exp_word(0, 25'h200));
        @(negedge clk_sys);
        rd = 2'b00;
        idle(4);
        req_before = mreq[0];
        abort_mon = 1'b1;
        reset = 1'b1;
        @(negedge clk_sys);
        reset = 1'b0;
        chk("t4_wait_low", {31'h0, wt[0]}, 32'h0);
        chk("t4_din_zero", {16'h0, din[0]}, 32'h0);
        chk("t4_req_held", {31'h0, mreq[0]}, {31'h0, req_before});
        idle(15);
        chk("t4_no_new_toggle", tog_cnt[0] - n0, 32'h1);
        abort_mon = 1'b0;
        strobe(2'b01, 25'h200);
        chk("t4_refetch_wait", {31'h0, seen[0]}, 32'h1);

        // no-prefetch instance with wrapping base
        idle(5);
        n1 = tog_cnt[1];
        waits = 0;
        for (int k = 0; k < 4; k++) begin
            strobe(2'b10, 25'(2 * k));
            if (seen[1]) waits++;
            idle(12);
        end
        chk("t6_toggles", tog_cnt[1] - n1, 32'h4);
        chk("t6_waits", waits, 32'h4);
        chk("t5_addr0", {10'h0, tog_log1[n1]}, {10'h0, 22'h3FFFFF});
        chk("t5_wrap", {10'h0, tog_log1[n1 + 1]}, 32'h0);

        // randomized traffic
        last = 25'd0;
        for (int it = 0; it < 200; it++) begin
            lat = $urandom_range(2, 10);
            r = $urandom_range(0, 9);
            if (r < 6) a = last + 25'd2;
            else if (r < 8) a = 25'($urandom_range(0, 65535));
            else if (r == 8) a = 25'h10000 - 25'($urandom_range(0, 6));
            else a = 25'($urandom_range(65536, 33554431));
            a[0] = 1'($urandom_range(0, 1));
            last = a & 25'h1FFFFFE;
            strobe(2'($urandom_range(1, 3)), a);
            idle($urandom_range(0, 12));
        end

        idle(40);
        chk("q0_drained", q0.size(), 32'h0);
        chk("q1_drained", q1.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
